deck_shuffler: RTL and testbench

Card-source end of the deal interface: on request, builds a fresh 52-card deck, permutes it in place with a hardware Fisher-Yates shuffle driven by a 16-bit LFSR, then streams the cards one at a time to the game controller over a valid/ready handshake. It sits between the pseudo-random source and the blackjack controller, which raises `shuffle_flag` and loads `card` while `load_flag` is high.

---
 rtl/deck_shuffler_pkg.sv | 40 ++++
 rtl/deck_shuffler_if.sv | 33 +++
 rtl/deck_shuffler_lfsr16.sv | 32 +++
 rtl/deck_shuffler.sv | 134 +++++++++++++
 tb/tb_deck_shuffler.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/deck_shuffler_pkg.sv
// deck_pkg: shared definitions for the card source and the game controller.
//   NUM_CARDS   - cards in a deck (52)
//   LFSR_TAPS   - Galois taps for x^16+x^14+x^13+x^11+1
//   card_t      - 6-bit card code, suit*13 + rank
//   state_t     - deck_shuffler FSM states
//   card_value  - blackjack value of a card code (ace counts 1)
//   idx_mask    - all-ones mask covering index i, i.e. 2^ceil(log2(i+1))-1
package deck_pkg;

  localparam int          NUM_CARDS = 52;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef logic [5:0] card_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_SHUFFLE,
    ST_STREAM,
    ST_DONE
  } state_t;

  function automatic logic [3:0] card_value(input card_t c);
    card_t rank;
    rank = c % 6'd13;
    if (rank == 6'd0)       card_value = 4'd1;
    else if (rank <= 6'd9)  card_value = rank[3:0] + 4'd1;
    else                    card_value = 4'd10;
  endfunction

  // Smear the highest set bit downwards; six bits need three steps.
  function automatic logic [5:0] idx_mask(input logic [5:0] i);
    logic [5:0] m;
    m = i | (i >> 1);
    m = m | (m >> 2);
    m = m | (m >> 4);
    return m;
  endfunction

endpackage

// File: rtl/deck_shuffler_if.sv
// deck_shuffler_if: deal channel between the card source and the game controller.
//   shuffle_flag - level request from controller (high = deal a deck, low = abort/release)
//   load_flag    - deck available or exhausted (STREAM / DONE)
//   card_valid / card_ready / card - valid/ready card stream
//   remaining    - undelivered cards
//   done         - one-cycle pulse on the 52nd transfer
//   card_value   - blackjack value of card (only with DECK_CARD_VALUE_EN)
// master = card source, slave = controller.
interface deck_shuffler_if;
  import deck_pkg::*;

  logic       shuffle_flag;
  logic       load_flag;
  logic       card_valid;
  logic       card_ready;
  card_t      card;
  logic [5:0] remaining;
  logic       done;
`ifdef DECK_CARD_VALUE_EN
  logic [3:0] card_value;

  modport master (input shuffle_flag, card_ready,
                  output load_flag, card_valid, card, remaining, done, card_value);
  modport slave  (output shuffle_flag, card_ready,
                  input load_flag, card_valid, card, remaining, done, card_value);
`else
  modport master (input shuffle_flag, card_ready,
                  output load_flag, card_valid, card, remaining, done);
  modport slave  (output shuffle_flag, card_ready,
                  input load_flag, card_valid, card, remaining, done);
`endif

endinterface

// File: rtl/deck_shuffler_lfsr16.sv
// lfsr16: free-running 16-bit Galois LFSR, advances every clock.
//   clk    - system clock
//   rst    - asynchronous active-low reset, loads SEED (0 is replaced by 1)
//   lfsr_o - current LFSR state
module lfsr16
  import deck_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] lfsr_o
);

  // An all-zero state would lock up the register.
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q >> 1;
    if (lfsr_q[0]) lfsr_d = lfsr_d ^ LFSR_TAPS;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr_q <= SEED_EFF;
    else      lfsr_q <= lfsr_d;
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/deck_shuffler.sv
// deck_shuffler: builds a 52-card deck, Fisher-Yates shuffles it in place using
// an LFSR, and streams the cards over a valid/ready channel.
//   clk  - system clock
//   rst  - asynchronous active-low reset
//   deal - deck_shuffler_if.master (request, card stream, status)
// Optional build macro: DECK_CARD_VALUE_EN adds the card_value decoder.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | waiting for shuffle_flag, LFSR free-runs for entropy
// INIT    | deck[i] = i, one entry per cycle
// SHUFFLE | swap deck[i] with random j<=i, retry on rejected j
// STREAM  | present deck[k], advance on valid & ready
// DONE    | deck exhausted, wait for shuffle_flag low
module deck_shuffler
  import deck_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  deck_shuffler_if.master  deal
);

  state_t      state_q, state_d;
  logic [5:0]  idx_q, idx_d;    // INIT write index, SHUFFLE position i
  logic [5:0]  rd_q, rd_d;      // STREAM read pointer k
  logic        done_q, done_d;
  card_t       deck_q [NUM_CARDS];

  logic [15:0] lfsr;
  logic [5:0]  cand_j;
  logic        accept;
  logic        lfsr_unused;

  lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .lfsr_o (lfsr)
  );

  assign lfsr_unused = ^lfsr[15:6];

  // Masking keeps the rejection rate below one half for every i.
  assign cand_j = lfsr[5:0] & idx_mask(idx_q);
  assign accept = (cand_j <= idx_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      rd_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rd_q    <= rd_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rd_d    = rd_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (deal.shuffle_flag) begin
          state_d = ST_INIT;
          idx_d   = '0;
        end
      end
      ST_INIT: begin
        if (!deal.shuffle_flag)                   state_d = ST_IDLE;
        else if (idx_q == 6'(NUM_CARDS - 1))      state_d = ST_SHUFFLE;
        else                                      idx_d   = idx_q + 6'd1;
      end
      ST_SHUFFLE: begin
        if (!deal.shuffle_flag) begin
          state_d = ST_IDLE;
        end else if (accept) begin
          idx_d = idx_q - 6'd1;
          if (idx_q == 6'd1) begin
            state_d = ST_STREAM;
            rd_d    = '0;
          end
        end
      end
      ST_STREAM: begin
        if (!deal.shuffle_flag) begin
          state_d = ST_IDLE;
        end else if (deal.card_ready) begin
          rd_d = rd_q + 6'd1;
          if (rd_q == 6'(NUM_CARDS - 1)) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (!deal.shuffle_flag) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Deck storage has no reset; its contents only matter after INIT rewrites it.
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      deck_q[idx_q] <= idx_q;
    end else if (state_q == ST_SHUFFLE && accept) begin
      deck_q[idx_q]  <= deck_q[cand_j];
      deck_q[cand_j] <= deck_q[idx_q];
    end
  end

  always_comb begin
    deal.load_flag  = (state_q == ST_STREAM) || (state_q == ST_DONE);
    deal.card_valid = (state_q == ST_STREAM);
    deal.done       = done_q;
    deal.card       = '0;
    deal.remaining  = '0;
    if (state_q == ST_STREAM) begin
      deal.card      = deck_q[rd_q];
      deal.remaining = 6'(NUM_CARDS) - rd_q;
    end
  end

`ifdef DECK_CARD_VALUE_EN
  assign deal.card_value = deal.card_valid ? card_value(deal.card) : 4'd0;
`endif

endmodule

// File: tb/tb_deck_shuffler.sv
// tb_deck_shuffler: randomized self-checking bench for deck_shuffler.
// The reference model replays the shuffle from the seed and the request cycle
// using plain integer arithmetic on an int array.
module tb_deck_shuffler;
  import deck_pkg::*;

  localparam logic [15:0] SEED_MAIN = 16'h1234;

  typedef int deck_arr_t [52];

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic shuffle_flag;
  logic card_ready;
  int   cyc;
  int   n_cmp = 0;
  int   n_err = 0;
  int   z_cards[$];

  always #5 clk = ~clk;

  deck_shuffler_if dif();
  deck_shuffler_if zif();

  assign dif.shuffle_flag = shuffle_flag;
  assign dif.card_ready   = card_ready;
  assign zif.shuffle_flag = shuffle_flag;
  assign zif.card_ready   = 1'b1;

  deck_shuffler #(.SEED(SEED_MAIN)) dut   (.clk(clk), .rst(rst), .deal(dif));
  deck_shuffler #(.SEED(16'h0000))  dut_z (.clk(clk), .rst(rst), .deal(zif));

  // Cycle index since reset release: after the n-th rising edge cyc == n.
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  // Zero-seed instance always has ready high, so every valid cycle is a transfer.
  always @(negedge clk) begin
    if (rst && zif.card_valid) z_cards.push_back(int'(zif.card));
  end

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    n_cmp++;
    if (obs !== 32'(exp)) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

`ifdef DECK_CARD_VALUE_EN
  function automatic int ref_value(input int c);
    int rank;
    rank = c % 13;
    if (rank == 0) return 1;
    if (rank < 10) return rank + 1;
    return 10;
  endfunction
`endif

  // Request raised in the interval where cyc == t_req. The LFSR seen during
  // interval n is step^n(seed); INIT spans 52 intervals after the request edge.
  task automatic model_deal(input logic [15:0] seed, input int t_req,
                            output deck_arr_t deck, output int first_cyc);
    logic [15:0] l;
    int i, j, msk, tmp, m;
    l = (seed == 16'h0000) ? 16'h0001 : seed;
    for (int n = 0; n < t_req + 53; n++) l = lfsr_step(l);
    for (int c = 0; c < 52; c++) deck[c] = c;
    m = t_req + 53;
    i = 51;
    while (i > 0) begin
      msk = 1;
      while (msk < i) msk = msk * 2 + 1;
      j = int'(l[5:0]) & msk;
      if (j <= i) begin
        tmp = deck[i]; deck[i] = deck[j]; deck[j] = tmp;
        i--;
      end
      l = lfsr_step(l);
      m++;
    end
    first_cyc = m;
  endtask

  task automatic check_perm(input string tag, input deck_arr_t s);
    int cnt[52];
    int dups, missing;
    dups = 0; missing = 0;
    for (int v = 0; v < 52; v++) cnt[v] = 0;
    for (int c = 0; c < 52; c++) begin
      if (s[c] >= 0 && s[c] < 52) cnt[s[c]]++;
    end
    for (int v = 0; v < 52; v++) begin
      if (cnt[v] == 0) missing++;
      if (cnt[v] > 1)  dups += cnt[v] - 1;
    end
    chk({tag, "_dups"}, dups, 0);
    chk({tag, "_missing"}, missing, 0);
  endtask

  // Called on a negedge with the DUT idle. Leaves shuffle_flag high unless aborted.
  task automatic run_deal(input bit rnd_ready, input int abort_after, output deck_arr_t seen);
    deck_arr_t exp;
    int  first, k, waited, prev;
    bit  stalled;
    for (int c = 0; c < 52; c++) seen[c] = -1;
    shuffle_flag = 1'b1;
    card_ready   = 1'b0;
    model_deal(SEED_MAIN, cyc, exp, first);
    waited = 0;
    @(negedge clk);
    while (!dif.card_valid && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    if (!dif.card_valid) begin
      chk("first_valid_timeout", 0, 1);
      return;
    end
    chk("latency", cyc, first);
    chk("remaining_start", dif.remaining, 52);
    chk("load_flag_stream", dif.load_flag, 1);
    k = 0; stalled = 1'b0; prev = 0;
    while (k < 52) begin
      chk("card_valid", dif.card_valid, 1);
      chk("card", dif.card, exp[k]);
      chk("remaining", dif.remaining, 52 - k);
      chk("done_early", dif.done, 0);
      if (stalled) chk("hold", dif.card, prev);
`ifdef DECK_CARD_VALUE_EN
      chk("card_value", dif.card_value, ref_value(exp[k]));
`endif
      if (k == abort_after) begin
        shuffle_flag = 1'b0;
        card_ready   = 1'b0;
        @(negedge clk);
        chk("abort_valid", dif.card_valid, 0);
        chk("abort_load", dif.load_flag, 0);
        chk("abort_remaining", dif.remaining, 0);
        chk("abort_done", dif.done, 0);
        repeat (3) begin
          @(negedge clk);
          chk("abort_no_done", dif.done, 0);
        end
        return;
      end
      card_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      prev = int'(dif.card);
      @(negedge clk);
      if (card_ready) begin
        seen[k] = prev;
        k++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
      end
    end
    chk("done_pulse", dif.done, 1);
    chk("done_valid", dif.card_valid, 0);
    chk("done_load", dif.load_flag, 1);
    chk("done_remaining", dif.remaining, 0);
`ifdef DECK_CARD_VALUE_EN
    chk("done_card_value", dif.card_value, 0);
`endif
    card_ready = 1'b0;
    @(negedge clk);
    chk("done_one_cycle", dif.done, 0);
    repeat (5) @(negedge clk);
    chk("no_restart_valid", dif.card_valid, 0);
    chk("no_restart_load", dif.load_flag, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    deck_arr_t seq_a, seq_b, seq_t, exp_z;
    int t_a, first_z, waited, diffs, nz;
    shuffle_flag = 1'b0;
    card_ready   = 1'b0;
    rst          = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_load", dif.load_flag, 0);
    chk("rst_valid", dif.card_valid, 0);
    chk("rst_card", dif.card, 0);
    chk("rst_remaining", dif.remaining, 0);
    chk("rst_done", dif.done, 0);
`ifdef DECK_CARD_VALUE_EN
    chk("rst_card_value", dif.card_value, 0);
`endif
    rst = 1'b1;

    // Run A: fixed timing, ready held high; zero-seed instance dealt alongside.
    while (cyc != 5) @(negedge clk);
    t_a = cyc;
    run_deal(1'b0, -1, seq_a);
    check_perm("deal_a", seq_a);
    model_deal(16'h0001, t_a, exp_z, first_z);
    waited = 0;
    while (z_cards.size() < 52 && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    chk("zero_seed_count", z_cards.size(), 52);
    diffs = 0;
    nz = (z_cards.size() < 52) ? z_cards.size() : 52;
    for (int c = 0; c < nz; c++) if (z_cards[c] != exp_z[c]) diffs++;
    chk("zero_seed_seq", diffs, 0);
    shuffle_flag = 1'b0;
    @(negedge clk);
    chk("release_load", dif.load_flag, 0);

    // Backpressure with a random idle gap before the request.
    repeat ($urandom_range(1, 20)) @(negedge clk);
    run_deal(1'b1, -1, seq_t);
    check_perm("backpressure", seq_t);
    shuffle_flag = 1'b0;
    @(negedge clk);

    // Abort after ten transfers, then a fresh full deck.
    repeat ($urandom_range(1, 20)) @(negedge clk);
    run_deal(1'b0, 10, seq_t);
    @(negedge clk);
    run_deal(1'b0, -1, seq_t);
    check_perm("after_abort", seq_t);
    shuffle_flag = 1'b0;
    @(negedge clk);

    // Reset asserted mid-stream between clock edges.
    shuffle_flag = 1'b1;
    card_ready   = 1'b1;
    waited = 0;
    while (!dif.card_valid && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    chk("reset_test_valid", dif.card_valid, 1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst_load", dif.load_flag, 0);
    chk("midrst_valid", dif.card_valid, 0);
    chk("midrst_card", dif.card, 0);
    chk("midrst_remaining", dif.remaining, 0);
    chk("midrst_done", dif.done, 0);
    shuffle_flag = 1'b0;
    card_ready   = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_load", dif.load_flag, 0);

    // Run B: same timing from reset as run A, with backpressure.
    while (cyc != 5) @(negedge clk);
    run_deal(1'b1, -1, seq_b);
    diffs = 0;
    for (int c = 0; c < 52; c++) if (seq_b[c] != seq_a[c]) diffs++;
    chk("determinism", diffs, 0);
    shuffle_flag = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
